// File: rtl/alarm_ctrl_pkg.sv
// Shared types and defaults for the alarm controller: FSM states, set_type
// field codes and the default timing parameters.
package alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } alm_state_t;

    localparam logic [1:0] FIELD_MIN = 2'd2;
    localparam logic [1:0] FIELD_HR  = 2'd3;

    localparam int RING_SECS_DEF   = 60;
    localparam int SNOOZE_SECS_DEF = 300;
    localparam int MAX_SNOOZE_DEF  = 3;

    localparam logic [7:0] ALM_HR_RST  = 8'h06;
    localparam logic [7:0] ALM_MIN_RST = 8'h00;

endpackage

// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the clock/keypad side (master) and the alarm
// controller (slave): time digits, set/ack/snooze strobes and alarm status.
interface alarm_ctrl_if;

    logic       tick_1s;
    logic [3:0] hr1, hr0, min1, min0, sec1, sec0;
    logic       alm_on;
    logic       set_en;
    logic [1:0] set_type;
    logic [7:0] set_val;
    logic       ack;
    logic       snooze;
    logic [7:0] alm_hr, alm_min;
    logic       buzzer;
    logic       ringing, snoozing;
    logic [1:0] snooze_left;

    modport master (
        output tick_1s, hr1, hr0, min1, min0, sec1, sec0,
        output alm_on, set_en, set_type, set_val, ack, snooze,
        input  alm_hr, alm_min, buzzer, ringing, snoozing, snooze_left
    );

    modport slave (
        input  tick_1s, hr1, hr0, min1, min0, sec1, sec0,
        input  alm_on, set_en, set_type, set_val, ack, snooze,
        output alm_hr, alm_min, buzzer, ringing, snoozing, snooze_left
    );

endinterface

// File: rtl/alarm_match.sv
// Combinational BCD checks for alarm-time loads and the current-time versus
// alarm-time compare (a match requires seconds == 00).
module alarm_match (
    input  logic [3:0] hr1,
    input  logic [3:0] hr0,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic [7:0] alm_hr,
    input  logic [7:0] alm_min,
    input  logic [7:0] set_val,
    output logic       time_match,
    output logic       hr_ok,
    output logic       min_ok
);

    logic bcd_ok;

    // With both nibbles valid BCD, a plain magnitude compare orders like decimal.
    assign bcd_ok     = (set_val[7:4] <= 4'd9) && (set_val[3:0] <= 4'd9);
    assign hr_ok      = bcd_ok && (set_val <= 8'h23);
    assign min_ok     = bcd_ok && (set_val <= 8'h59);
    assign time_match = ({hr1, hr0} == alm_hr) && ({min1, min0} == alm_min) &&
                        ({sec1, sec0} == 8'h00);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: stores the alarm time, rings at the matching second with
// a 1 s on/off buzzer, and handles ack, snooze and auto-stop.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int RING_SECS   = RING_SECS_DEF,
    parameter int SNOOZE_SECS = SNOOZE_SECS_DEF,
    parameter int MAX_SNOOZE  = MAX_SNOOZE_DEF
) (
    input logic         clk,
    input logic         reset,
    alarm_ctrl_if.slave bus
);

    localparam int RING_W = $clog2(RING_SECS + 1);
    localparam int SNZ_W  = $clog2(SNOOZE_SECS + 1);

    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS - 1);
    localparam logic [RING_W-1:0] RING_ONE  = RING_W'(1);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SECS);
    localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);
    localparam logic [1:0]        SNZ_MAX   = 2'(MAX_SNOOZE);

    alm_state_t        state;
    logic [RING_W-1:0] ring_cnt;
    logic [SNZ_W-1:0]  snz_cnt;
    logic [1:0]        snz_left_q;
    logic [7:0]        alm_hr_q, alm_min_q;
    logic              buzzer_q, ringing_q, snoozing_q;
    logic              time_match, hr_ok, min_ok;

    alarm_match u_match (
        .hr1        (bus.hr1),
        .hr0        (bus.hr0),
        .min1       (bus.min1),
        .min0       (bus.min0),
        .sec1       (bus.sec1),
        .sec0       (bus.sec0),
        .alm_hr     (alm_hr_q),
        .alm_min    (alm_min_q),
        .set_val    (bus.set_val),
        .time_match (time_match),
        .hr_ok      (hr_ok),
        .min_ok     (min_ok)
    );

    // Alarm time registers load independently of the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alm_hr_q  <= ALM_HR_RST;
            alm_min_q <= ALM_MIN_RST;
        end else if (bus.set_en) begin
            if (bus.set_type == FIELD_HR && hr_ok)
                alm_hr_q <= bus.set_val;
            if (bus.set_type == FIELD_MIN && min_ok)
                alm_min_q <= bus.set_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            buzzer_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            snz_left_q <= SNZ_MAX;
            ring_cnt   <= '0;
            snz_cnt    <= '0;
        end else if (!bus.alm_on) begin
            state      <= ST_IDLE;
            buzzer_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            ring_cnt   <= '0;
            snz_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.tick_1s && time_match) begin
                        state      <= ST_RING;
                        ringing_q  <= 1'b1;
                        buzzer_q   <= 1'b1;
                        ring_cnt   <= '0;
                        snz_left_q <= SNZ_MAX;
                    end
                end
                ST_RING: begin
                    // ack beats snooze; a snooze with none left falls through to tick handling.
                    if (bus.ack) begin
                        state     <= ST_IDLE;
                        ringing_q <= 1'b0;
                        buzzer_q  <= 1'b0;
                        ring_cnt  <= '0;
                    end else if (bus.snooze && snz_left_q != 2'd0) begin
                        state      <= ST_SNOOZE;
                        ringing_q  <= 1'b0;
                        snoozing_q <= 1'b1;
                        buzzer_q   <= 1'b0;
                        snz_left_q <= snz_left_q - 2'd1;
                        snz_cnt    <= SNZ_LOAD;
                    end else if (bus.tick_1s) begin
                        if (ring_cnt == RING_LAST) begin
                            state     <= ST_IDLE;
                            ringing_q <= 1'b0;
                            buzzer_q  <= 1'b0;
                            ring_cnt  <= '0;
                        end else begin
                            ring_cnt <= ring_cnt + RING_ONE;
                            buzzer_q <= ~buzzer_q;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (bus.ack) begin
                        state      <= ST_IDLE;
                        snoozing_q <= 1'b0;
                        snz_cnt    <= '0;
                    end else if (bus.tick_1s) begin
                        if (snz_cnt == SNZ_ONE) begin
                            state      <= ST_RING;
                            snoozing_q <= 1'b0;
                            ringing_q  <= 1'b1;
                            buzzer_q   <= 1'b1;
                            ring_cnt   <= '0;
                            snz_cnt    <= '0;
                        end else begin
                            snz_cnt <= snz_cnt - SNZ_ONE;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    buzzer_q   <= 1'b0;
                    ringing_q  <= 1'b0;
                    snoozing_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alm_hr      = alm_hr_q;
    assign bus.alm_min     = alm_min_q;
    assign bus.buzzer      = buzzer_q;
    assign bus.ringing     = ringing_q;
    assign bus.snoozing    = snoozing_q;
    assign bus.snooze_left = snz_left_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios followed by random traffic, all
// outputs compared every cycle against a seconds-based reference model.
module tb_alarm_ctrl;
    import alarm_ctrl_pkg::*;

    localparam int RING_SECS   = 60;
    localparam int SNOOZE_SECS = 300;
    localparam int MAX_SNOOZE  = 3;

    logic clk = 1'b0;
    logic reset;

    alarm_ctrl_if bus ();

    alarm_ctrl #(
        .RING_SECS   (RING_SECS),
        .SNOOZE_SECS (SNOOZE_SECS),
        .MAX_SNOOZE  (MAX_SNOOZE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time of day in seconds, alarm in decimal hours/minutes,
    // mode 0 = idle, 1 = ringing, 2 = snoozing.
    int tod;
    int m_mode, m_ring_ticks, m_snz_remain, m_left, m_ahr, m_amin;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic drive_digits();
        int h, m, s;
        h = tod / 3600;
        m = (tod / 60) % 60;
        s = tod % 60;
        bus.hr1  = 4'(h / 10);  bus.hr0  = 4'(h % 10);
        bus.min1 = 4'(m / 10);  bus.min0 = 4'(m % 10);
        bus.sec1 = 4'(s / 10);  bus.sec0 = 4'(s % 10);
    endtask

    task automatic model_reset();
        m_mode = 0; m_ring_ticks = 0; m_snz_remain = 0;
        m_left = MAX_SNOOZE; m_ahr = 6; m_amin = 0;
    endtask

    task automatic model_update();
        int tens, units, val;
        bit match;
        match = (tod / 3600 == m_ahr) && ((tod / 60) % 60 == m_amin) && (tod % 60 == 0);
        if (!bus.alm_on) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (bus.tick_1s && match) begin
                m_mode = 1; m_ring_ticks = 0; m_left = MAX_SNOOZE;
            end
        end else if (m_mode == 1) begin
            if (bus.ack) m_mode = 0;
            else if (bus.snooze && m_left > 0) begin
                m_mode = 2; m_left--; m_snz_remain = SNOOZE_SECS;
            end else if (bus.tick_1s) begin
                m_ring_ticks++;
                if (m_ring_ticks >= RING_SECS) m_mode = 0;
            end
        end else begin
            if (bus.ack) m_mode = 0;
            else if (bus.tick_1s) begin
                m_snz_remain--;
                if (m_snz_remain == 0) begin m_mode = 1; m_ring_ticks = 0; end
            end
        end
        if (bus.set_en) begin
            tens  = int'(bus.set_val[7:4]);
            units = int'(bus.set_val[3:0]);
            val   = tens * 10 + units;
            if (tens < 10 && units < 10) begin
                if (bus.set_type == 2'd3 && val <= 23) m_ahr = val;
                if (bus.set_type == 2'd2 && val <= 59) m_amin = val;
            end
        end
    endtask

    task automatic check_all();
        chk("alm_hr", 32'(bus.alm_hr), 32'(to_bcd(m_ahr)));
        chk("alm_min", 32'(bus.alm_min), 32'(to_bcd(m_amin)));
        chk("ringing", 32'(bus.ringing), 32'(m_mode == 1));
        chk("snoozing", 32'(bus.snoozing), 32'(m_mode == 2));
        chk("buzzer", 32'(bus.buzzer), 32'(m_mode == 1 && (m_ring_ticks % 2) == 0));
        chk("snooze_left", 32'(bus.snooze_left), 32'(m_left));
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
        check_all();
        bus.tick_1s = 1'b0; bus.set_en = 1'b0; bus.ack = 1'b0; bus.snooze = 1'b0;
    endtask

    task automatic tick();
        tod = (tod + 1) % 86400;
        drive_digits();
        bus.tick_1s = 1'b1;
        step();
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_alarm(input logic [1:0] typ, input logic [7:0] val);
        bus.set_en = 1'b1; bus.set_type = typ; bus.set_val = val;
        step();
    endtask

    // Put the clock at 07:29:59 and tick into 07:30:00.
    task automatic trigger_0730();
        tod = 7 * 3600 + 29 * 60 + 59;
        drive_digits();
        step();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.tick_1s = 1'b0; bus.alm_on = 1'b0; bus.set_en = 1'b0;
        bus.set_type = 2'd0; bus.set_val = 8'h00; bus.ack = 1'b0; bus.snooze = 1'b0;
        tod = 0;
        drive_digits();
        model_reset();
        @(negedge clk);
        check_all();
        chk("rst_alm_hr", 32'(bus.alm_hr), 32'h06);
        @(negedge clk);
        reset = 1'b0;

        // Alarm-time loads: invalid values and no-op types are ignored.
        set_alarm(2'd3, 8'h24);  chk("hr_0x24_ignored", 32'(bus.alm_hr), 32'h06);
        set_alarm(2'd3, 8'h1A);  chk("hr_0x1A_ignored", 32'(bus.alm_hr), 32'h06);
        set_alarm(2'd3, 8'h23);  chk("hr_0x23_loaded", 32'(bus.alm_hr), 32'h23);
        set_alarm(2'd1, 8'h11);
        set_alarm(2'd2, 8'h60);  chk("min_0x60_ignored", 32'(bus.alm_min), 32'h00);
        set_alarm(2'd3, 8'h07);
        set_alarm(2'd2, 8'h30);  chk("min_0x30_loaded", 32'(bus.alm_min), 32'h30);

        // Trigger at 07:30:00, ring pattern, auto-stop after RING_SECS ticks.
        bus.alm_on = 1'b1;
        trigger_0730();
        chk("trig_ringing", 32'(bus.ringing), 32'd1);
        chk("trig_buzzer", 32'(bus.buzzer), 32'd1);
        tick();
        chk("ring_toggle", 32'(bus.buzzer), 32'd0);
        ticks(RING_SECS - 2);
        chk("ring_before_stop", 32'(bus.ringing), 32'd1);
        tick();
        chk("ring_autostop", 32'(bus.ringing), 32'd0);

        // Snooze, re-ring after SNOOZE_SECS, snooze limit, then ack.
        trigger_0730();
        bus.snooze = 1'b1; step();
        chk("snz_flag", 32'(bus.snoozing), 32'd1);
        chk("snz_left2", 32'(bus.snooze_left), 32'd2);
        chk("snz_buzzer", 32'(bus.buzzer), 32'd0);
        ticks(SNOOZE_SECS - 1);
        chk("snz_still", 32'(bus.snoozing), 32'd1);
        tick();
        chk("snz_rering", 32'(bus.ringing), 32'd1);
        for (int k = 0; k < 2; k++) begin
            bus.snooze = 1'b1; step();
            ticks(SNOOZE_SECS);
        end
        chk("snz_left0", 32'(bus.snooze_left), 32'd0);
        bus.snooze = 1'b1; step();
        chk("snz4_ignored", 32'(bus.ringing), 32'd1);
        bus.ack = 1'b1; step();
        chk("ack_idle", 32'(bus.ringing), 32'd0);

        // ack beats snooze; dropping alm_on in snooze ends the event.
        trigger_0730();
        bus.ack = 1'b1; bus.snooze = 1'b1; step();
        chk("ack_wins_ring", 32'(bus.ringing), 32'd0);
        chk("ack_wins_snz", 32'(bus.snoozing), 32'd0);
        trigger_0730();
        bus.snooze = 1'b1; step();
        bus.alm_on = 1'b0; step();
        chk("almoff_idle", 32'(bus.snoozing), 32'd0);
        bus.alm_on = 1'b1;
        ticks(SNOOZE_SECS + 10);
        chk("almoff_no_rering", 32'(bus.ringing), 32'd0);

        // Asynchronous reset between clock edges mid-ring.
        trigger_0730();
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_buzzer", 32'(bus.buzzer), 32'd0);
        chk("arst_ringing", 32'(bus.ringing), 32'd0);
        chk("arst_alm_hr", 32'(bus.alm_hr), 32'h06);
        chk("arst_alm_min", 32'(bus.alm_min), 32'h00);
        model_reset();
        @(negedge clk);
        check_all();
        reset = 1'b0;
        ticks(SNOOZE_SECS + 10);
        chk("arst_no_rering", 32'(bus.ringing), 32'd0);

        // Random traffic.
        for (int c = 0; c < 15000; c++) begin
            if (m_mode == 0 && $urandom_range(0, 49) == 0) begin
                tod = m_ahr * 3600 + m_amin * 60 - int'($urandom_range(1, 3));
                if (tod < 0) tod += 86400;
                drive_digits();
            end
            if ($urandom_range(0, 2) == 0) begin
                tod = (tod + 1) % 86400;
                drive_digits();
                bus.tick_1s = 1'b1;
            end
            if ($urandom_range(0, 399) == 0) bus.ack = 1'b1;
            if ($urandom_range(0, 39) == 0) bus.snooze = 1'b1;
            if ($urandom_range(0, 79) == 0) begin
                bus.set_en   = 1'b1;
                bus.set_type = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 0)
                    bus.set_val = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
                else
                    bus.set_val = 8'($urandom);
            end
            if (bus.alm_on && $urandom_range(0, 999) == 0) bus.alm_on = 1'b0;
            else if (!bus.alm_on && $urandom_range(0, 9) == 0) bus.alm_on = 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
